serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Digit-serial two's-complement subtractor: computes `minuend - subtrahend` over `WIDTH/DIGIT` clock cycles with one registered carry. It is the inverse-operation companion to the team's combinational ripple-carry adder and uses far less area for 32-bit datapaths. Operands arrive through a valid/ready handshake; the result leaves through a second valid/ready handshake. It sits between an operand-issue stage and a result consumer that tolerate multi-cycle latency.

## Interface
- `WIDTH`, 32, operand and result width in bits; must be a multiple of `DIGIT`
- `DIGIT`, 4, bits processed per cycle; 1 ≤ `DIGIT` ≤ `WIDTH`
- `clk`  in  1  single clock; all state changes on the rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `in_valid`  in  1  operands valid
- `in_ready`  out  1  block can accept operands
- `minuend`  in  WIDTH  operand A; sampled only on input handshake
- `subtrahend`  in  WIDTH  operand B; sampled only on input handshake
- `out_valid`  out  1  result valid
- `out_ready`  in  1  consumer accepts the result
- `difference`  out  WIDTH  (A − B) mod 2^WIDTH
- `borrow_out`  out  1  1 when A < B (unsigned)
- `overflow`  out  1  signed overflow of A − B

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - `in_ready`=1.
  - When `in_valid` is 1, latch A, B and the digit counter (0), set carry=1, then go to RUN.
- RUN:
  - Each cycle, digit `k` = `A[k*DIGIT +: DIGIT] + ~B[k*DIGIT +: DIGIT] + carry`.
  - Store the low `DIGIT` bits into the result shift register. Update carry from bit `DIGIT`.
  - After digit `WIDTH/DIGIT−1`, go to DONE.
- DONE:
  - `out_valid`=1.
  - `borrow_out` = ~final carry.
  - `overflow` = (A[W−1] ≠ B[W−1]) && (difference[W−1] ≠ A[W−1]).
  - When `out_ready` is 1, go to IDLE.
- `in_ready` is 0 in RUN and DONE. Inputs offered then are not consumed and must be held by the producer.
- `difference`, `borrow_out` and `overflow` hold stable while `out_valid`=1. Outside DONE they keep their last values; consumers must not rely on them there.
- Arithmetic is modulo 2^WIDTH. There is no saturation.
- `DIGIT`=`WIDTH`: RUN lasts exactly one cycle.

## Timing
- Reset (`rst_n`=0 at an edge):
  - State forced to IDLE, counter 0, carry 0.
  - `out_valid`=0, `difference`=0, `borrow_out`=0, `overflow`=0.
  - `in_ready` reads 1 from the edge after reset is applied. Handshakes while `rst_n`=0 are ignored.
- Reset mid-RUN or mid-DONE: the operation is discarded and no `out_valid` pulse appears.
- Latency: input handshake at edge N gives `out_valid`=1 from edge N+`WIDTH/DIGIT`.
- Throughput: with `out_ready` tied high, one operation per `WIDTH/DIGIT`+2 cycles. The cycles are handshake edge, RUN cycles, the DONE cycle, then return to IDLE.
- `out_valid` stays high through back-pressure until `out_ready` is sampled high. The DONE→IDLE transition and the next input handshake cannot occur on the same edge.
- All outputs are registered or decoded only from state. There is no combinational input→output path.

## Structure
- Package `serial_sub_pkg`:
  - state enum `sub_state_t` {IDLE, RUN, DONE}
  - localparam `NDIG` = `WIDTH/DIGIT`
  - counter width `$clog2(NDIG)` (minimum 1)
- Sub-module `digit_sub_slice`: combinational `DIGIT`-bit `a + ~b + cin` giving `{cout, sum}`. It is instantiated once.
- The top level holds the FSM, operand shift registers (shift right by `DIGIT` each RUN cycle), result shift register, carry flop and counter.
- Elaboration check: `WIDTH % DIGIT == 0`.

## Test plan
- Basic case, after reset, `out_ready`=1:
  - A=100, B=58 → `difference`=42, `borrow_out`=0, `overflow`=0.
  - `out_valid` rises exactly 8 cycles after the handshake, at defaults.
- Borrow and wrap: A=0, B=1 → `difference`=0xFFFFFFFF, `borrow_out`=1, `overflow`=0.
- Signed overflow: A=0x80000000, B=1 → `difference`=0x7FFFFFFF, `borrow_out`=0, `overflow`=1.
  - A=0x7FFFFFFF, B=0xFFFFFFFF → `overflow`=1.
- Back-pressure:
  - Hold `out_ready`=0 for 5 cycles in DONE → `out_valid` and `difference` stay stable, `in_ready`=0 throughout.
  - Raising `out_ready` frees the block; `in_ready`=1 on the next cycle.
- Reset mid-RUN: assert `rst_n`=0 at the 3rd RUN cycle → next cycle state is IDLE, `out_valid`=0, `difference`=0. No stale result afterward.
- Random regression:
  - 10 random pairs (seed 0) at `DIGIT`=1, 4 and 32.
  - Each result equals `A−B` mod 2^32 with correct `borrow_out` and `overflow`.
  - Compare `A = difference + B` through the existing ripple-carry adder.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// Shared types and sizing helpers for the digit-serial subtractor.
package serial_sub_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} sub_state_t;

    localparam int WIDTH_DEF = 32;
    localparam int DIGIT_DEF = 4;
    localparam int NDIG      = WIDTH_DEF / DIGIT_DEF;

    // A single-digit datapath still needs a one-bit counter.
    function automatic int cntWidth(input int nDig);
        return (nDig > 1) ? $clog2(nDig) : 1;
    endfunction

endpackage

// File: rtl/digit_sub_slice.sv
// One DIGIT-wide slice of a - b computed as a + ~b + cin.
module digit_sub_slice
    import serial_sub_pkg::*;
#(
    parameter int DIGIT = DIGIT_DEF
) (
    input  logic [DIGIT-1:0] a_i,
    input  logic [DIGIT-1:0] b_i,
    input  logic             cin_i,
    output logic [DIGIT-1:0] sum_o,
    output logic             cout_o
);

    assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, ~b_i} + {{DIGIT{1'b0}}, cin_i};

endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial two's-complement subtractor: minuend - subtrahend over
// WIDTH/DIGIT cycles, with valid/ready handshakes on both sides.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DIGIT = DIGIT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] minuend,
    input  logic [WIDTH-1:0] subtrahend,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] difference,
    output logic             borrow_out,
    output logic             overflow
);

    localparam int NUM_DIG = WIDTH / DIGIT;
    localparam int CNT_W   = cntWidth(NUM_DIG);
    localparam logic [CNT_W-1:0] LAST_DIG = CNT_W'(NUM_DIG - 1);

    generate
        if ((DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_bad_params
            $error("serial_subtractor: WIDTH must be a positive multiple of DIGIT");
        end
    endgenerate

    sub_state_t        state_q;
    sub_state_t        state_d;
    logic [WIDTH-1:0]  opA_q;
    logic [WIDTH-1:0]  opB_q;
    logic [WIDTH-1:0]  res_q;
    logic [WIDTH-1:0]  diff_q;
    logic              carry_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              borrow_q;
    logic              ovf_q;
    logic [DIGIT-1:0]  sliceSum;
    logic              sliceCout;
    logic              lastDig;
    logic [WIDTH-1:0]  resNext;

    digit_sub_slice #(.DIGIT(DIGIT)) u_slice (
        .a_i    (opA_q[DIGIT-1:0]),
        .b_i    (opB_q[DIGIT-1:0]),
        .cin_i  (carry_q),
        .sum_o  (sliceSum),
        .cout_o (sliceCout)
    );

    assign lastDig = (cnt_q == LAST_DIG);
    // New digits enter at the top so digit 0 ends up in the LSBs.
    assign resNext = (res_q >> DIGIT) | (WIDTH'(sliceSum) << (WIDTH - DIGIT));

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = RUN;
            RUN:     if (lastDig)   state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    // The top bits of the operand digits on the last step are the sign bits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            opA_q    <= '0;
            opB_q    <= '0;
            res_q    <= '0;
            diff_q   <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        opA_q   <= minuend;
                        opB_q   <= subtrahend;
                        cnt_q   <= '0;
                        carry_q <= 1'b1;
                    end
                end
                RUN: begin
                    opA_q   <= opA_q >> DIGIT;
                    opB_q   <= opB_q >> DIGIT;
                    res_q   <= resNext;
                    carry_q <= sliceCout;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (lastDig) begin
                        diff_q   <= resNext;
                        borrow_q <= ~sliceCout;
                        ovf_q    <= (opA_q[DIGIT-1] != opB_q[DIGIT-1]) &&
                                    (sliceSum[DIGIT-1] != opA_q[DIGIT-1]);
                    end
                end
                default: ;
            endcase
        end
    end

    assign difference = diff_q;
    assign borrow_out = borrow_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench: three subtractor instances (DIGIT = 4, 1, 32) against
// an arithmetic reference model, plus directed handshake and reset checks.
module tb_serial_subtractor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] minuend;
    logic [31:0] subtrahend;

    logic        rdy [3];
    logic        vld [3];
    logic [31:0] diff [3];
    logic        bor [3];
    logic        ovf [3];

    logic [31:0] gotDiff [3];
    logic        gotBor [3];
    logic        gotOvf [3];
    int          lat [3];

    int nAssert = 0;
    int nFail   = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(32), .DIGIT(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[0]),
        .minuend(minuend), .subtrahend(subtrahend), .out_valid(vld[0]),
        .out_ready(out_ready), .difference(diff[0]), .borrow_out(bor[0]), .overflow(ovf[0]));

    serial_subtractor #(.WIDTH(32), .DIGIT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[1]),
        .minuend(minuend), .subtrahend(subtrahend), .out_valid(vld[1]),
        .out_ready(out_ready), .difference(diff[1]), .borrow_out(bor[1]), .overflow(ovf[1]));

    serial_subtractor #(.WIDTH(32), .DIGIT(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[2]),
        .minuend(minuend), .subtrahend(subtrahend), .out_valid(vld[2]),
        .out_ready(out_ready), .difference(diff[2]), .borrow_out(bor[2]), .overflow(ovf[2]));

    function automatic int digOf(input int i);
        return (i == 0) ? 4 : ((i == 1) ? 1 : 32);
    endfunction

    // Reference: plain modular, unsigned and widened signed arithmetic.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] d, output logic bo, output logic ov);
        longint sd;
        longint maxS = 64'sd2147483647;
        longint minS = -64'sd2147483648;
        d  = a - b;
        bo = (a < b);
        sd = longint'($signed(a)) - longint'($signed(b));
        ov = (sd > maxS) || (sd < minS);
    endfunction

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAssert++;
        assert (obs === exp) else begin
            nFail++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("[TB] check %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic waitIdle();
        int n = 0;
        while (!(rdy[0] && rdy[1] && rdy[2]) && (n < 100)) begin
            @(posedge clk); #1;
            n++;
        end
        checkVal("all idle", 32'({rdy[2], rdy[1], rdy[0]}), 32'd7);
    endtask

    // Issue one operation to all instances and capture each first result.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
        bit seen [3];
        for (int i = 0; i < 3; i++) begin
            seen[i] = 1'b0;
            lat[i]  = 0;
        end
        @(negedge clk);
        minuend    = a;
        subtrahend = b;
        in_valid   = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int c = 1; (c <= 64) && !(seen[0] && seen[1] && seen[2]); c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 3; i++) begin
                if (vld[i] && !seen[i]) begin
                    seen[i]    = 1'b1;
                    lat[i]     = c;
                    gotDiff[i] = diff[i];
                    gotBor[i]  = bor[i];
                    gotOvf[i]  = ovf[i];
                end
            end
        end
    endtask

    task automatic checkOutput(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] eD;
        logic        eB;
        logic        eO;
        model(a, b, eD, eB, eO);
        for (int i = 0; i < 3; i++) begin
            checkVal($sformatf("d%0d diff %0h-%0h", digOf(i), a, b), gotDiff[i], eD);
            checkVal($sformatf("d%0d borrow %0h-%0h", digOf(i), a, b), 32'(gotBor[i]), 32'(eB));
            checkVal($sformatf("d%0d overflow %0h-%0h", digOf(i), a, b), 32'(gotOvf[i]), 32'(eO));
            checkVal($sformatf("d%0d latency", digOf(i)), 32'(lat[i]), 32'(32 / digOf(i)));
            checkVal($sformatf("d%0d diff+b==a", digOf(i)), gotDiff[i] + b, a);
        end
    endtask

    task automatic doOp(input logic [31:0] a, input logic [31:0] b);
        applyStimulus(a, b);
        checkOutput(a, b);
        waitIdle();
    endtask

    initial begin
        int n;
        int pulses;
        logic [31:0] bpExp;

        rst_n      = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        minuend    = '0;
        subtrahend = '0;
        void'($urandom(0));

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            checkVal($sformatf("d%0d reset in_ready", digOf(i)), 32'(rdy[i]), 32'd1);
            checkVal($sformatf("d%0d reset out_valid", digOf(i)), 32'(vld[i]), 32'd0);
            checkVal($sformatf("d%0d reset diff", digOf(i)), diff[i], 32'd0);
            checkVal($sformatf("d%0d reset borrow", digOf(i)), 32'(bor[i]), 32'd0);
            checkVal($sformatf("d%0d reset overflow", digOf(i)), 32'(ovf[i]), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Directed arithmetic cases
        doOp(32'd100, 32'd58);
        doOp(32'd0, 32'd1);
        doOp(32'h8000_0000, 32'd1);
        doOp(32'h7FFF_FFFF, 32'hFFFF_FFFF);

        // Back-pressure on the DIGIT=4 instance
        out_ready = 1'b0;
        bpExp = 32'd1000 - 32'd1;
        @(negedge clk);
        minuend    = 32'd1000;
        subtrahend = 32'd1;
        in_valid   = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!vld[0] && (n < 64)) begin
            @(posedge clk); #1;
            n++;
        end
        checkVal("bp latency", 32'(n), 32'd8);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            checkVal("bp out_valid held", 32'(vld[0]), 32'd1);
            checkVal("bp diff held", diff[0], bpExp);
            checkVal("bp in_ready low", 32'(rdy[0]), 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        checkVal("bp release in_ready", 32'(rdy[0]), 32'd1);
        checkVal("bp release out_valid", 32'(vld[0]), 32'd0);
        waitIdle();

        // Reset during the third RUN cycle
        @(negedge clk);
        minuend    = 32'd12345;
        subtrahend = 32'd99;
        in_valid   = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        checkVal("midrun reset in_ready", 32'(rdy[0]), 32'd1);
        checkVal("midrun reset out_valid", 32'(vld[0]), 32'd0);
        checkVal("midrun reset diff", diff[0], 32'd0);
        checkVal("midrun reset borrow", 32'(bor[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (vld[0] || vld[1] || vld[2]) pulses++;
        end
        checkVal("midrun no stale result", 32'(pulses), 32'd0);
        waitIdle();

        // Random regression
        for (int r = 0; r < 10; r++) begin
            doOp($urandom, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
